// File: rtl/axis_block_serializer.sv
// Transmit-side AXI-Stream master: splits whole cipher blocks into TDATA_WIDTH beats,
// least-significant word first, with tkeep/tlast generated for the final block of a message.
module axis_block_serializer #(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned BLOCK_WIDTH = 128,
    parameter int unsigned BEATS       = BLOCK_WIDTH / TDATA_WIDTH,
    parameter int unsigned CNT_W       = $clog2(BLOCK_WIDTH / 8) + 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     block_valid,
    output logic                     block_ready,
    input  logic [BLOCK_WIDTH-1:0]   block_data,
    input  logic                     block_last,
    input  logic [CNT_W-1:0]         block_bytes,
    output logic                     tvalid,
    input  logic                     tready,
    output logic [TDATA_WIDTH-1:0]   tdata,
    output logic [TDATA_WIDTH/8-1:0] tkeep,
    output logic                     tlast
);
    localparam int unsigned KW = TDATA_WIDTH / 8;
    localparam int unsigned NB = BLOCK_WIDTH / 8;
    localparam int unsigned BW = $clog2(BEATS + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_q,  state_d;
    logic [BLOCK_WIDTH-1:0] shreg_q,  shreg_d;
    logic [BW-1:0]          beat_q,   beat_d;
    logic [BW-1:0]          nbeats_q, nbeats_d;
    logic [CNT_W-1:0]       nbytes_q, nbytes_d;
    logic                   last_q,   last_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q,  tlast_d;
    logic [TDATA_WIDTH-1:0] tdata_q,  tdata_d;
    logic [KW-1:0]          tkeep_q,  tkeep_d;

    logic                   final_hs;
    logic                   accept;
    logic [CNT_W-1:0]       n_in;
    logic [BW-1:0]          nb_in;
    logic [BW-1:0]          beat_nx;
    logic [BLOCK_WIDTH-1:0] blk_mask;

    // Only the final beat of a message block carries a partial keep.
    function automatic logic [KW-1:0] keep_for(input logic [BW-1:0]    beat,
                                               input logic [BW-1:0]    nb,
                                               input logic [CNT_W-1:0] n,
                                               input logic             last);
        int unsigned rem;
        keep_for = '1;
        if (last && beat == nb - BW'(1)) begin
            rem = 32'(n) - (32'(nb) - 32'd1) * KW;
            for (int unsigned i = 0; i < KW; i++) begin
                keep_for[i] = (i < rem);
            end
        end
    endfunction

    always_comb begin
        n_in = (block_last && block_bytes != '0 && 32'(block_bytes) <= NB)
             ? block_bytes : CNT_W'(NB);
        nb_in = BW'((32'(n_in) + KW - 1) / KW);
        blk_mask = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            blk_mask[8*k +: 8] = (k < 32'(n_in)) ? block_data[8*k +: 8] : 8'h00;
        end
    end

    assign final_hs    = tvalid_q && tready && (beat_q == nbeats_q - BW'(1));
    assign block_ready = !Rst && (state_q == IDLE || final_hs);
    assign accept      = block_valid && block_ready;
    assign beat_nx     = beat_q + BW'(1);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        beat_d   = beat_q;
        nbeats_d = nbeats_q;
        nbytes_d = nbytes_q;
        last_d   = last_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        // Accept takes priority so a final-beat handshake rolls straight into the next block.
        if (accept) begin
            state_d  = SEND;
            shreg_d  = blk_mask >> TDATA_WIDTH;
            beat_d   = '0;
            nbeats_d = nb_in;
            nbytes_d = n_in;
            last_d   = block_last;
            tvalid_d = 1'b1;
            tdata_d  = blk_mask[TDATA_WIDTH-1:0];
            tkeep_d  = keep_for('0, nb_in, n_in, block_last);
            tlast_d  = block_last && (nb_in == BW'(1));
        end else if (final_hs) begin
            state_d  = IDLE;
            beat_d   = '0;
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = 1'b0;
        end else if (tvalid_q && tready) begin
            beat_d  = beat_nx;
            tdata_d = shreg_q[TDATA_WIDTH-1:0];
            shreg_d = shreg_q >> TDATA_WIDTH;
            tkeep_d = keep_for(beat_nx, nbeats_q, nbytes_q, last_q);
            tlast_d = last_q && (beat_nx == nbeats_q - BW'(1));
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            beat_q   <= '0;
            nbeats_q <= '0;
            nbytes_q <= '0;
            last_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            beat_q   <= beat_d;
            nbeats_q <= nbeats_d;
            nbytes_q <= nbytes_d;
            last_q   <= last_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
        end
    end

    assign tvalid = tvalid_q;
    assign tdata  = tdata_q;
    assign tkeep  = tkeep_q;
    assign tlast  = tlast_q;

endmodule
